// File: rtl/note_key_tx.sv
// note_key_tx: 16-key debouncer and lowest-key priority encoder driving a UART 8N1 transmitter.
// Build option NOTE_RELEASE_EN: releasing all keys also transmits a 0x00 frame.
module note_key_tx #(
    parameter int unsigned CLKS_PER_BIT    = 10417,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] keys,
    output logic        tx,
    output logic        tx_busy,
    output logic [7:0]  cur_code,
    output logic        frame_done
);
    localparam int unsigned NKEYS  = 16;
    localparam int unsigned CODE_W = 8;
    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [NKEYS-1:0]  r_sync1, r_sync2, r_cand, r_stable;
    logic [DB_W-1:0]   r_db_cnt;
    logic [CODE_W-1:0] r_cur_code, r_last_code, r_pend_code;
    logic              r_pending;
    logic [CODE_W-1:0] w_code;
    logic              w_changed, w_queue, w_load;

    state_t            r_state, w_state_nxt;
    logic [BAUD_W-1:0] r_baud, w_baud_nxt;
    logic [2:0]        r_bit_idx, w_bit_idx_nxt;
    logic [7:0]        r_shift, w_shift_nxt;
    logic              r_tx, w_tx_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;

    // Synchronise the key vector and accept it once it has held still long enough.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_cand   <= '0;
            r_stable <= '0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= keys;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_cand) begin
                r_cand   <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                if (r_db_cnt != DB_LAST) begin
                    r_db_cnt <= r_db_cnt + DB_W'(1);
                end
                if (r_db_cnt == DB_LAST) begin
                    r_stable <= r_cand;
                end
            end
        end
    end

    // Lowest pressed key wins; code is 1-based, 0 means nothing pressed.
    always_comb begin
        w_code = '0;
        for (int i = int'(NKEYS) - 1; i >= 0; i--) begin
            if (r_stable[i]) begin
                w_code = CODE_W'(i + 1);
            end
        end
    end

    assign w_changed = (r_cur_code != r_last_code);
`ifdef NOTE_RELEASE_EN
    assign w_queue = w_changed;
`else
    assign w_queue = w_changed && (r_cur_code != '0);
`endif

    // Latest change overwrites a frame that has not started yet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cur_code  <= '0;
            r_last_code <= '0;
            r_pend_code <= '0;
            r_pending   <= 1'b0;
        end else begin
            r_cur_code <= w_code;
            if (w_changed) begin
                r_last_code <= r_cur_code;
            end
            if (w_queue) begin
                r_pend_code <= r_cur_code;
                r_pending   <= 1'b1;
            end else if (w_load) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Baud counter reloads on every state/bit entry; outputs follow the next state.
    always_comb begin
        w_state_nxt   = r_state;
        w_baud_nxt    = r_baud;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_load        = 1'b0;
        w_tx_nxt      = 1'b1;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_pending) begin
                    w_load      = 1'b1;
                    w_shift_nxt = r_pend_code;
                    w_baud_nxt  = BAUD_LAST;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_baud == '0) begin
                    w_baud_nxt    = BAUD_LAST;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = S_DATA;
                end else begin
                    w_baud_nxt = r_baud - BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (r_baud == '0) begin
                    w_baud_nxt = BAUD_LAST;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud - BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (r_baud == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_baud_nxt = r_baud - BAUD_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_shift_nxt[w_bit_idx_nxt];
            default: w_tx_nxt = 1'b1;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (w_state_nxt == S_STOP) && (w_baud_nxt == '0);
    end

    assign tx         = r_tx;
    assign tx_busy    = r_busy;
    assign cur_code   = r_cur_code;
    assign frame_done = r_done;

endmodule

// File: tb/tb_note_key_tx.sv
// Bench for note_key_tx: directed table, multi-cycle corner sequences and randomized key segments
// checked by a line-level UART receiver and a lowest-key reference model.
`timescale 1ns/1ps
module tb_note_key_tx;
    localparam int unsigned CPB = 8;
    localparam int unsigned DEB = 16;
`ifdef NOTE_RELEASE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] keys;
    logic        tx, tx_busy, frame_done;
    logic [7:0]  cur_code;

    int n_checks = 0;
    int n_errors = 0;

    note_key_tx #(.CLKS_PER_BIT(CPB), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .keys(keys), .tx(tx),
        .tx_busy(tx_busy), .cur_code(cur_code), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference encoder: isolate the lowest set bit arithmetically, code = its position + 1.
    function automatic logic [7:0] ref_code(input logic [15:0] v);
        int unsigned x;
        int unsigned lsb;
        x   = 32'(v);
        lsb = x & (~x + 32'd1);
        return (x == 0) ? 8'd0 : 8'($clog2(lsb) + 1);
    endfunction

    // Line-level UART receiver plus frame length / frame_done / inter-frame gap tracking.
    logic [7:0] rx_q[$];
    bit         mon_act;
    int         mon_c, mon_k;
    logic [7:0] mon_byte;
    int         busy_len, done_cnt, gap_len, last_gap;
    logic       prev_busy, prev_done;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_act   = 1'b0;
            mon_c     = 0;
            busy_len  = 0;
            done_cnt  = 0;
            gap_len   = 0;
            prev_busy = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (!mon_act) begin
                if (tx === 1'b0) begin
                    mon_act = 1'b1;
                    mon_c   = 0;
                end
            end else begin
                mon_c++;
            end
            if (mon_act && (mon_c % int'(CPB)) == int'(CPB) / 2) begin
                mon_k = mon_c / int'(CPB);
                if (mon_k == 0) begin
                    check("start_bit", 32'(tx), 32'd0);
                end else if (mon_k <= 8) begin
                    mon_byte[mon_k-1] = tx;
                end else begin
                    check("stop_bit", 32'(tx), 32'd1);
                    rx_q.push_back(mon_byte);
                    mon_act = 1'b0;
                end
            end
            if (frame_done === 1'b1) done_cnt++;
            if (tx_busy === 1'b1) begin
                if (!prev_busy) begin
                    last_gap = gap_len;
                    gap_len  = 0;
                end
                busy_len++;
            end else begin
                if (prev_busy) begin
                    check("frame_len", 32'(busy_len), 32'(10 * CPB));
                    check("done_pulses", 32'(done_cnt), 32'd1);
                    check("done_on_last", 32'(prev_done), 32'd1);
                    busy_len = 0;
                    done_cnt = 0;
                end else begin
                    check("done_idle", 32'(frame_done), 32'd0);
                end
                gap_len++;
            end
            prev_busy = tx_busy;
            prev_done = frame_done;
        end
    end

    typedef struct {
        logic [15:0] keys;
        logic [7:0]  exp_code;
        bit          exp_frame;
    } vec_t;
    vec_t vec[8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v, g, d;
        logic [7:0]  mc, prev;
        int          ng, seen_code, seen_busy;
        bit          found;

        vec[0] = '{16'h0208, 8'd4,  1'b1};
        vec[1] = '{16'h0000, 8'd0,  REL};
        vec[2] = '{16'h0208, 8'd4,  1'b1};
        vec[3] = '{16'h8001, 8'd1,  1'b1};
        vec[4] = '{16'h8000, 8'd16, 1'b1};
        vec[5] = '{16'h8000, 8'd16, 1'b0};
        vec[6] = '{16'hFFFF, 8'd1,  1'b1};
        vec[7] = '{16'h0000, 8'd0,  REL};

        rst_n = 1'b0;
        keys  = '0;
        tick(3);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_code", 32'(cur_code), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        tick(4);

        // Press keys[11]: exact encode latency, frame start, single frame while held.
        keys = 16'h0800;
        tick(19);
        check("lat_before", 32'(cur_code), 32'd0);
        tick(1);
        check("lat_code", 32'(cur_code), 32'd12);
        tick(2);
        check("start_busy", 32'(tx_busy), 32'd1);
        check("start_tx", 32'(tx), 32'd0);
        tick(250);
        check("k11_frames", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check("k11_byte", 32'(rx_q[0]), 32'h0C);
        rx_q.delete();

        // Directed table applied in sequence from code 12.
        for (int i = 0; i < 8; i++) begin
            keys = vec[i].keys;
            tick(int'(DEB) + 8);
            check($sformatf("vec%0d_code", i), 32'(cur_code), 32'(vec[i].exp_code));
            tick(120);
            check($sformatf("vec%0d_nframes", i), 32'(rx_q.size()), 32'(vec[i].exp_frame));
            if (rx_q.size() > 0) check($sformatf("vec%0d_byte", i), 32'(rx_q[0]), 32'(vec[i].exp_code));
            rx_q.delete();
        end

        // Bouncing key never settles: no code, no frame.
        seen_code = 0;
        seen_busy = 0;
        for (int t = 0; t < 20; t++) begin
            keys[11] = ~keys[11];
            for (int c = 0; c < 5; c++) begin
                tick(1);
                if (cur_code != 8'd0) seen_code++;
                if (tx_busy) seen_busy++;
            end
        end
        keys = '0;
        for (int c = 0; c < 60; c++) begin
            tick(1);
            if (cur_code != 8'd0) seen_code++;
            if (tx_busy) seen_busy++;
        end
        check("bounce_code", 32'(seen_code), 32'd0);
        check("bounce_busy", 32'(seen_busy), 32'd0);
        check("bounce_frames", 32'(rx_q.size()), 32'd0);
        rx_q.delete();

        // Change keys mid-frame: first frame unaltered, second follows one idle cycle later.
        keys  = 16'h0001;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            tick(1);
            if (tx_busy) found = 1'b1;
        end
        check("mid_start_seen", 32'(found), 32'd1);
        tick(20);
        keys = 16'h8000;
        tick(220);
        check("mid_frames", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() > 0) check("mid_byte0", 32'(rx_q[0]), 32'h01);
        if (rx_q.size() > 1) check("mid_byte1", 32'(rx_q[1]), 32'h10);
        check("mid_gap", 32'(last_gap), 32'd1);
        rx_q.delete();

        // Reset during DATA: line idles at once and nothing is resent.
        keys  = 16'h0020;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            tick(1);
            if (tx_busy) found = 1'b1;
        end
        check("rst_start_seen", 32'(found), 32'd1);
        tick(int'(CPB) * 3);
        rx_q.delete();
        keys  = '0;
        rst_n = 1'b0;
        tick(1);
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(tx_busy), 32'd0);
        check("midrst_code", 32'(cur_code), 32'd0);
        rst_n     = 1'b1;
        seen_busy = 0;
        for (int c = 0; c < 200; c++) begin
            tick(1);
            if (tx_busy) seen_busy++;
        end
        check("midrst_busy_after", 32'(seen_busy), 32'd0);
        check("midrst_frames", 32'(rx_q.size()), 32'd0);
        rx_q.delete();

        // Random segments: short glitch bursts, then a settled vector judged by the model.
        prev = 8'd0;
        for (int s = 0; s < 30; s++) begin
            ng = int'($urandom_range(0, 5));
            g  = keys;
            for (int j = 0; j < ng; j++) begin
                d = 16'($urandom);
                if (d == 16'd0) d = 16'h0001;
                g    = g ^ d;
                keys = g;
                tick(int'($urandom_range(1, 10)));
            end
            case ($urandom_range(0, 3))
                0:       v = 16'h0000;
                1:       v = 16'h0001 << $urandom_range(0, 15);
                default: v = 16'($urandom) & 16'($urandom);
            endcase
            keys = v;
            mc   = ref_code(v);
            tick(int'(DEB) + 8);
            check($sformatf("rnd%0d_code", s), 32'(cur_code), 32'(mc));
            tick(120);
            check($sformatf("rnd%0d_nframes", s), 32'(rx_q.size()),
                  32'((mc != prev) && (mc != 8'd0 || REL)));
            if (rx_q.size() > 0) check($sformatf("rnd%0d_byte", s), 32'(rx_q[0]), 32'(mc));
            rx_q.delete();
            prev = mc;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
